// File: rtl/mixer_tune_ctrl_pkg.sv
// Shared definitions for the NCO/mixer tuning controller.
//   - default widths and settle length
//   - controller state encoding
//   - tuning command record at the default widths
package mixer_tune_ctrl_pkg;

   localparam int MTC_PHASE_WIDTH   = 24;
   localparam int MTC_DWELL_WIDTH   = 16;
   localparam int MTC_SETTLE_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } tune_state_e;

   typedef struct packed {
      logic [MTC_PHASE_WIDTH-1:0] start;
      logic [MTC_PHASE_WIDTH-1:0] stop;
      logic [MTC_PHASE_WIDTH-1:0] step;
      logic [MTC_DWELL_WIDTH-1:0] dwell;
      logic                       sweep;
   } tune_cmd_t;

endpackage

// File: rtl/mixer_tune_ctrl_tune_step_calc.sv
// Next sweep point calculation (purely combinational).
//   cur_inc_i   : phase increment currently driven to the NCO
//   step_inc_i  : sweep step
//   start_inc_i : sweep start, used when the sweep wraps
//   stop_inc_i  : sweep upper bound, inclusive
//   next_inc_o  : increment for the next sweep point
//   wrap_o      : next point is the start value (overflowed or passed stop)
module tune_step_calc
   import mixer_tune_ctrl_pkg::*;
#(
   parameter int PHASE_WIDTH = MTC_PHASE_WIDTH
) (
   input  logic [PHASE_WIDTH-1:0] cur_inc_i,
   input  logic [PHASE_WIDTH-1:0] step_inc_i,
   input  logic [PHASE_WIDTH-1:0] start_inc_i,
   input  logic [PHASE_WIDTH-1:0] stop_inc_i,
   output logic [PHASE_WIDTH-1:0] next_inc_o,
   output logic                   wrap_o
);

   logic [PHASE_WIDTH:0] sum;

   // One extra bit so an add that overflows the tuning word reads as a wrap
   // rather than a small increment near zero.
   assign sum        = {1'b0, cur_inc_i} + {1'b0, step_inc_i};
   assign wrap_o     = sum[PHASE_WIDTH] || (sum[PHASE_WIDTH-1:0] > stop_inc_i);
   assign next_inc_o = wrap_o ? start_inc_i : sum[PHASE_WIDTH-1:0];

endmodule

// File: rtl/mixer_tune_ctrl.sv
// NCO + mixer tuning sequencer for the SDR receive chain.
// Accepts tuning commands, drives the NCO phase increment / phase clear and
// holds mix_valid low while the NCO, mixer and filter pipelines settle after
// every frequency change. Supports single tone and stepped sweeps.
//   clk, arst      : clock, asynchronous active-high reset
//   cfg_valid/ready: command handshake, ready only in IDLE or RUN
//   cfg_*          : start/stop/step increments, dwell, sweep select
//   phase_inc      : registered NCO phase increment
//   phase_clr      : one-cycle NCO accumulator clear on a new command
//   mix_valid      : mixer output usable downstream
//   busy           : high while settling
//   sweep_wrap     : one-cycle pulse when a sweep returns to start
//
// state  | meaning
// IDLE   | no tuning applied since reset, waiting for a command
// SETTLE | frequency just changed, pipelines filling, mix_valid low
// RUN    | output valid; single tone holds, sweep counts down dwell
module mixer_tune_ctrl
   import mixer_tune_ctrl_pkg::*;
#(
   parameter int PHASE_WIDTH   = MTC_PHASE_WIDTH,
   parameter int SETTLE_CYCLES = MTC_SETTLE_CYCLES,
   parameter int DWELL_WIDTH   = MTC_DWELL_WIDTH
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [PHASE_WIDTH-1:0] cfg_start_inc,
   input  logic [PHASE_WIDTH-1:0] cfg_stop_inc,
   input  logic [PHASE_WIDTH-1:0] cfg_step_inc,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic                   cfg_sweep,
   output logic [PHASE_WIDTH-1:0] phase_inc,
   output logic                   phase_clr,
   output logic                   mix_valid,
   output logic                   busy,
   output logic                   sweep_wrap
);

   localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

   typedef struct packed {
      logic [PHASE_WIDTH-1:0] start;
      logic [PHASE_WIDTH-1:0] stop;
      logic [PHASE_WIDTH-1:0] step;
      logic [DWELL_WIDTH-1:0] dwell;
      logic                   sweep;
   } cmd_t;

   tune_state_e            state_q, state_d;
   cmd_t                   cmd_q, cmd_d;
   logic [SCW-1:0]         settle_q, settle_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [PHASE_WIDTH-1:0] phase_inc_q, phase_inc_d;
   logic                   phase_clr_q, phase_clr_d;
   logic                   mix_valid_q, mix_valid_d;
   logic                   busy_q, busy_d;
   logic                   wrap_q, wrap_d;

   logic                   accept;
   logic [DWELL_WIDTH-1:0] dwell_load;
   logic [PHASE_WIDTH-1:0] step_next;
   logic                   step_wrap;

   assign cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign accept     = cfg_valid && cfg_ready;
   // A dwell of zero is treated as one RUN cycle per point.
   assign dwell_load = (cmd_q.dwell == '0) ? '0 : cmd_q.dwell - DWELL_WIDTH'(1);

   tune_step_calc #(
      .PHASE_WIDTH (PHASE_WIDTH)
   ) u_step_calc (
      .cur_inc_i   (phase_inc_q),
      .step_inc_i  (cmd_q.step),
      .start_inc_i (cmd_q.start),
      .stop_inc_i  (cmd_q.stop),
      .next_inc_o  (step_next),
      .wrap_o      (step_wrap)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      settle_d    = settle_q;
      dwell_d     = dwell_q;
      phase_inc_d = phase_inc_q;
      phase_clr_d = 1'b0;
      mix_valid_d = mix_valid_q;
      busy_d      = busy_q;
      wrap_d      = 1'b0;

      // A new command takes priority over a dwell expiring in the same cycle.
      if (accept) begin
         cmd_d.start = cfg_start_inc;
         cmd_d.stop  = cfg_stop_inc;
         cmd_d.step  = cfg_step_inc;
         cmd_d.dwell = cfg_dwell;
         // A sweep that cannot advance degenerates to a single tone.
         cmd_d.sweep = cfg_sweep && (cfg_step_inc != '0) &&
                       (cfg_stop_inc >= cfg_start_inc);
         phase_inc_d = cfg_start_inc;
         phase_clr_d = 1'b1;
         mix_valid_d = 1'b0;
         busy_d      = 1'b1;
         settle_d    = SETTLE_LOAD;
         state_d     = ST_SETTLE;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               if (settle_q == '0) begin
                  state_d     = ST_RUN;
                  mix_valid_d = 1'b1;
                  busy_d      = 1'b0;
                  dwell_d     = dwell_load;
               end else begin
                  settle_d = settle_q - SCW'(1);
               end
            end
            ST_RUN: begin
               if (cmd_q.sweep) begin
                  if (dwell_q == '0) begin
                     // Steps keep phase continuity: no accumulator clear.
                     phase_inc_d = step_next;
                     wrap_d      = step_wrap;
                     mix_valid_d = 1'b0;
                     busy_d      = 1'b1;
                     settle_d    = SETTLE_LOAD;
                     state_d     = ST_SETTLE;
                  end else begin
                     dwell_d = dwell_q - DWELL_WIDTH'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         settle_q    <= '0;
         dwell_q     <= '0;
         phase_inc_q <= '0;
         phase_clr_q <= 1'b0;
         mix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         settle_q    <= settle_d;
         dwell_q     <= dwell_d;
         phase_inc_q <= phase_inc_d;
         phase_clr_q <= phase_clr_d;
         mix_valid_q <= mix_valid_d;
         busy_q      <= busy_d;
         wrap_q      <= wrap_d;
      end
   end

   assign phase_inc  = phase_inc_q;
   assign phase_clr  = phase_clr_q;
   assign mix_valid  = mix_valid_q;
   assign busy       = busy_q;
   assign sweep_wrap = wrap_q;

endmodule
